regfile_sb: RTL and testbench

- Parametrised successor to the 2-read/1-write pipeline register file.
- Provides NRD combinational read ports, NWR writeback ports with priority and write-through bypass, and an optional hard-wired zero register.
- Adds a per-register pending-write scoreboard, so ID can detect RAW hazards against in-flight EX/MEM results and stall.
- Sits between the ID stage (read, issue) and the WB stage(s) (write).

---
 rtl/regfile_sb.sv | 120 ++++++++++++
 tb/tb_regfile_sb.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Multi-port register file with write-through bypass and a per-register
// pending-write scoreboard for RAW hazard detection at issue.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   we/waddr/wdata    : NWR writeback ports, highest index wins on conflict
//   re/raddr/rdata    : NRD combinational read ports with bypass
//   rbusy             : read register still pending after this cycle's writes
//   iss_valid/iss_addr: issue of an instruction writing iss_addr
//   iss_full          : pending counter saturated, issue refused
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int CNT_W    = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NWR-1:0]        we,
  input  logic [NWR*ADDR_W-1:0] waddr,
  input  logic [NWR*DATA_W-1:0] wdata,
  input  logic [NRD-1:0]        re,
  input  logic [NRD*ADDR_W-1:0] raddr,
  output logic [NRD*DATA_W-1:0] rdata,
  output logic [NRD-1:0]        rbusy,
  input  logic                  iss_valid,
  input  logic [ADDR_W-1:0]     iss_addr,
  output logic                  iss_full
);

  localparam int NREG = 2 ** ADDR_W;
  localparam int DW   = $clog2(NWR + 1);
  // Wide enough that cnt + inc - dec never aliases; MSB flags underflow.
  localparam int SW   = CNT_W + DW + 1;
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic [DATA_W-1:0] regs    [NREG];
  logic [CNT_W-1:0]  cnt     [NREG];
  logic [CNT_W-1:0]  cnt_nxt [NREG];
  logic [DW-1:0]     dec     [NREG];
  logic [SW-1:0]     sum     [NREG];

  logic [ADDR_W-1:0] wa [NWR];
  logic [DATA_W-1:0] wd [NWR];
  logic [ADDR_W-1:0] ra [NRD];
  logic [DATA_W-1:0] rd [NRD];

  logic iss_zero;
  logic iss_inc;

  for (genvar i = 0; i < NWR; i++) begin : g_wunpack
    assign wa[i] = waddr[i*ADDR_W +: ADDR_W];
    assign wd[i] = wdata[i*DATA_W +: DATA_W];
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rpack
    assign ra[k] = raddr[k*ADDR_W +: ADDR_W];
    assign rdata[k*DATA_W +: DATA_W] = rd[k];
  end

  assign iss_zero = ZERO_REG && (iss_addr == '0);
  assign iss_full = !rst && iss_valid && !iss_zero
                    && (cnt[iss_addr] == CMAX);
  assign iss_inc  = iss_valid && !iss_full && !iss_zero;

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      dec[r]     = '0;
      sum[r]     = '0;
      cnt_nxt[r] = '0;
      for (int i = 0; i < NWR; i++) begin
        if (we[i] && (wa[i] == ADDR_W'(r)))
          dec[r] = dec[r] + DW'(1);
      end
      sum[r] = SW'(cnt[r])
             + SW'(iss_inc && (iss_addr == ADDR_W'(r)))
             - SW'(dec[r]);
      // Negative result means unscoreboarded writes: clamp at zero.
      if (!sum[r][SW-1])
        cnt_nxt[r] = sum[r][CNT_W-1:0];
      if (ZERO_REG && r == 0)
        cnt_nxt[r] = '0;
    end
  end

  always_comb begin
    for (int k = 0; k < NRD; k++) begin
      rd[k]    = '0;
      rbusy[k] = 1'b0;
      if (!rst && re[k] && !(ZERO_REG && ra[k] == '0)) begin
        rd[k] = regs[ra[k]];
        // Ascending scan: the highest matching port is applied last.
        for (int j = 0; j < NWR; j++) begin
          if (we[j] && (wa[j] == ra[k]))
            rd[k] = wd[j];
        end
        rbusy[k] = SW'(cnt[ra[k]]) > SW'(dec[ra[k]]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
    end else begin
      for (int i = 0; i < NWR; i++) begin
        if (we[i] && !(ZERO_REG && wa[i] == '0))
          regs[wa[i]] <= wd[i];
      end
      for (int r = 0; r < NREG; r++)
        cnt[r] <= cnt_nxt[r];
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: reset, bypass/priority, zero register,
// scoreboard RAW, saturation and simultaneous issue/writeback.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  we;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic [1:0]  re;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic        iss_full;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_sb dut (
    .clk(clk), .rst(rst),
    .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_full(iss_full)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    we = 2'b00; waddr = '0; wdata = '0;
    iss_valid = 1'b0; iss_addr = '0;
  endtask

  initial begin
    rst = 1'b1; idle(); re = 2'b00; raddr = '0;

    // 1. reset with conflicting write and issue
    we = 2'b11; waddr = {5'd3, 5'd3};
    wdata = {32'hDEAD0001, 32'hDEAD0000};
    iss_valid = 1'b1; iss_addr = 5'd3;
    re = 2'b11; raddr = {5'd3, 5'd3};
    settle();
    chk("rst_full", {31'd0, iss_full}, 32'd0);
    chk("rst_rdata0", rdata[31:0], 32'd0);
    chk("rst_rbusy", {30'd0, rbusy}, 32'd0);
    tick(); tick();
    rst = 1'b0; idle();
    settle();
    chk("post_rst_r3", rdata[31:0], 32'd0);
    chk("post_rst_busy", {30'd0, rbusy}, 32'd0);

    // 2. bypass with priority, then stored value
    we = 2'b11; waddr = {5'd7, 5'd7};
    wdata = {32'hBBBB0000, 32'hAAAA0000};
    re = 2'b01; raddr = {5'd0, 5'd7};
    settle();
    chk("byp_prio", rdata[31:0], 32'hBBBB0000);
    tick(); idle(); settle();
    chk("stored_r7", rdata[31:0], 32'hBBBB0000);
    raddr = {5'd7, 5'd7};
    settle();
    chk("re_off_p1", rdata[63:32], 32'd0);

    // 3. zero register
    we = 2'b11; waddr = {5'd0, 5'd0};
    wdata = {32'hFFFFFFFF, 32'hFFFFFFFF};
    iss_valid = 1'b1; iss_addr = 5'd0;
    re = 2'b11; raddr = {5'd0, 5'd0};
    settle();
    chk("z_rd0", rdata[31:0], 32'd0);
    chk("z_rd1", rdata[63:32], 32'd0);
    chk("z_full", {31'd0, iss_full}, 32'd0);
    tick(); we = 2'b00; tick(); tick(); tick();
    settle();
    chk("z_full_4", {31'd0, iss_full}, 32'd0);
    chk("z_busy", {30'd0, rbusy}, 32'd0);
    chk("z_rd_after", rdata[31:0], 32'd0);
    idle();

    // 4. scoreboard RAW on r5
    re = 2'b01; raddr = {5'd0, 5'd5};
    iss_valid = 1'b1; iss_addr = 5'd5;
    settle();
    chk("raw_self", {31'd0, rbusy[0]}, 32'd0);
    tick(); idle(); settle();
    chk("raw_busy", {31'd0, rbusy[0]}, 32'd1);
    we = 2'b10; waddr = {5'd5, 5'd0};
    wdata = {32'h12345678, 32'd0};
    settle();
    chk("raw_wb_busy", {31'd0, rbusy[0]}, 32'd0);
    chk("raw_wb_data", rdata[31:0], 32'h12345678);
    tick(); idle(); settle();
    chk("raw_after", {31'd0, rbusy[0]}, 32'd0);
    chk("raw_stored", rdata[31:0], 32'h12345678);

    // 5. saturation on r9
    raddr = {5'd0, 5'd9};
    iss_valid = 1'b1; iss_addr = 5'd9;
    tick(); tick(); tick();
    settle();
    chk("sat_full", {31'd0, iss_full}, 32'd1);
    tick(); idle(); settle();
    chk("sat_busy", {31'd0, rbusy[0]}, 32'd1);
    we = 2'b01; waddr = {5'd0, 5'd9}; wdata = {32'd0, 32'd1};
    settle();
    chk("sat_wb1", {31'd0, rbusy[0]}, 32'd1);
    tick(); wdata = {32'd0, 32'd2}; settle();
    chk("sat_wb2", {31'd0, rbusy[0]}, 32'd1);
    tick(); wdata = {32'd0, 32'd3}; settle();
    chk("sat_wb3", {31'd0, rbusy[0]}, 32'd0);
    chk("sat_wb3_d", rdata[31:0], 32'd3);
    tick(); wdata = {32'd0, 32'd4}; settle();
    chk("sat_extra", {31'd0, rbusy[0]}, 32'd0);
    tick(); idle();
    iss_valid = 1'b1; iss_addr = 5'd9;
    settle();
    chk("sat_floor", {31'd0, iss_full}, 32'd0);
    tick(); idle();
    we = 2'b01; waddr = {5'd0, 5'd9}; wdata = {32'd0, 32'd5};
    settle();
    chk("sat_cnt1", {31'd0, rbusy[0]}, 32'd0);
    tick(); idle();

    // dual writeback retires two pending writes at once
    raddr = {5'd0, 5'd10};
    iss_valid = 1'b1; iss_addr = 5'd10;
    tick(); tick(); idle();
    we = 2'b11; waddr = {5'd10, 5'd10};
    wdata = {32'h0000AAAA, 32'h00005555};
    settle();
    chk("dual_busy", {31'd0, rbusy[0]}, 32'd0);
    chk("dual_data", rdata[31:0], 32'h0000AAAA);
    tick(); idle();

    // 6. simultaneous issue and writeback on r4
    raddr = {5'd0, 5'd4};
    iss_valid = 1'b1; iss_addr = 5'd4;
    tick();
    we = 2'b01; waddr = {5'd0, 5'd4}; wdata = {32'd0, 32'h44};
    settle();
    chk("sim_busy", {31'd0, rbusy[0]}, 32'd0);
    chk("sim_data", rdata[31:0], 32'h44);
    chk("sim_full", {31'd0, iss_full}, 32'd0);
    tick(); idle(); settle();
    chk("sim_next", {31'd0, rbusy[0]}, 32'd1);

    // mid-run reset clears contents and scoreboard
    rst = 1'b1; re = 2'b01; raddr = {5'd0, 5'd7};
    settle();
    chk("rst2_rd", rdata[31:0], 32'd0);
    tick(); rst = 1'b0; settle();
    chk("rst2_r7", rdata[31:0], 32'd0);
    raddr = {5'd0, 5'd4};
    settle();
    chk("rst2_busy", {31'd0, rbusy[0]}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
